// File: rtl/resample_pkg.sv
// resample_pkg: shared rate indices and channel state encoding for the resampler output stage
package resample_pkg;
  localparam int RATE_32  = 0;
  localparam int RATE_441 = 1;
  localparam int RATE_48  = 2;
  localparam int RATE_96  = 3;
  localparam int RATE_192 = 4;
  typedef enum logic [1:0] {ST_FLUSH = 2'd0, ST_PRIME = 2'd1, ST_RUN = 2'd2} state_t;
endpackage

// File: rtl/resample_output_stage_if.sv
// resample_output_stage_if: per-channel write/pop/status buses of the output stage, channel c in slice c
// master drives rate/we/data/pop/flag_clr; slave returns data/ack/level/primed/underflow/overflow
interface resample_output_stage_if #(
  parameter int NUM_CH     = 8,
  parameter int NUM_RATE   = 5,
  parameter int DATA_W     = 24,
  parameter int DEPTH_LOG2 = 4
);
  logic [NUM_RATE*NUM_CH-1:0]       rate_i;
  logic [NUM_CH-1:0]                we_i;
  logic [DATA_W*NUM_CH-1:0]         data_i;
  logic [NUM_CH-1:0]                pop_i;
  logic [NUM_CH-1:0]                flag_clr_i;
  logic [DATA_W*NUM_CH-1:0]         data_o;
  logic [NUM_CH-1:0]                ack_o;
  logic [(DEPTH_LOG2+1)*NUM_CH-1:0] level_o;
  logic [NUM_CH-1:0]                primed_o;
  logic [NUM_CH-1:0]                underflow_o;
  logic [NUM_CH-1:0]                overflow_o;
  modport master (
    output rate_i, we_i, data_i, pop_i, flag_clr_i,
    input  data_o, ack_o, level_o, primed_o, underflow_o, overflow_o
  );
  modport slave (
    input  rate_i, we_i, data_i, pop_i, flag_clr_i,
    output data_o, ack_o, level_o, primed_o, underflow_o, overflow_o
  );
endinterface

// File: rtl/resample_chbuf.sv
// resample_chbuf: one channel's ring buffer with FLUSH/PRIME/RUN control, fill level and sticky flags
// in: rate (one-hot), we/wdata, pop, flag_clr; out: rdata/ack (registered), level, primed, underflow, overflow
module resample_chbuf
  import resample_pkg::*;
#(
  parameter int NUM_RATE    = 5,
  parameter int DATA_W      = 24,
  parameter int DEPTH       = 16,
  parameter int DEPTH_LOG2  = 4,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_RATE-1:0]   rate,
  input  logic                  we,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  pop,
  input  logic                  flag_clr,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ack,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  primed,
  output logic                  underflow,
  output logic                  overflow
);
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);
  state_t state, state_n;
  logic [NUM_RATE-1:0] rate_q;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_val;
  logic [LW-1:0] level_n;
  logic rate_bad, flush, empty, full, consume, wr_acc, uf_set, of_set;
  // A rate change acts in the cycle it is seen: the buffer is cleared on the same edge the state drops to FLUSH
  always_comb begin
    rate_bad = rate != rate_q || rate == '0;
    flush    = rate_bad || state == ST_FLUSH;
    empty    = level == '0;
    full     = level == FULL;
    consume  = !flush && state == ST_RUN && pop && !empty;
    uf_set   = !flush && state == ST_RUN && pop && empty;
    wr_acc   = !flush && we && (!full || consume);
    of_set   = !flush && we && full && !consume;
    level_n  = level + LW'(wr_acc) - LW'(consume);
    rd_val   = consume ? mem[rd_ptr] : '0;
    state_n  = rate_bad ? ST_FLUSH :
               state == ST_FLUSH ? ST_PRIME :
               state == ST_PRIME ? (level_n >= PRIME_L ? ST_RUN : ST_PRIME) :
               uf_set ? ST_PRIME : ST_RUN;
  end
  always_ff @(posedge clk) if (wr_acc) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= ST_FLUSH;
      rate_q    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rdata     <= '0;
      ack       <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      rate_q    <= rate;
      ack       <= pop;
      if (pop) rdata <= rd_val;
      wr_ptr    <= flush ? '0 : wr_ptr + DEPTH_LOG2'(wr_acc);
      rd_ptr    <= flush ? '0 : rd_ptr + DEPTH_LOG2'(consume);
      level     <= flush ? '0 : level_n;
      underflow <= uf_set || (underflow && !flag_clr);
      overflow  <= of_set || (overflow && !flag_clr);
    end
  assign primed = state == ST_RUN;
endmodule

// File: rtl/resample_output_stage.sv
// resample_output_stage: NUM_CH independent output buffers between the resampler muxer and the consumer
// clk, rst (async, active-low) plus the slave side of resample_output_stage_if
module resample_output_stage
  import resample_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int NUM_CH_LOG2 = 3,
  parameter int NUM_RATE    = 5,
  parameter int DATA_W      = 24,
  parameter int DEPTH       = 16,
  parameter int DEPTH_LOG2  = 4,
  parameter int PRIME_LEVEL = 4
) (
  input logic clk,
  input logic rst,
  resample_output_stage_if.slave bus
);
  localparam int LW = DEPTH_LOG2 + 1;
  // channel count is clamped to what NUM_CH_LOG2 can address
  for (genvar c = 0; c < NUM_CH && c < (1 << NUM_CH_LOG2); c++) begin : g_ch
    resample_chbuf #(
      .NUM_RATE(NUM_RATE), .DATA_W(DATA_W), .DEPTH(DEPTH),
      .DEPTH_LOG2(DEPTH_LOG2), .PRIME_LEVEL(PRIME_LEVEL)
    ) u_chbuf (
      .clk(clk),
      .rst(rst),
      .rate(bus.rate_i[c*NUM_RATE +: NUM_RATE]),
      .we(bus.we_i[c]),
      .wdata(bus.data_i[c*DATA_W +: DATA_W]),
      .pop(bus.pop_i[c]),
      .flag_clr(bus.flag_clr_i[c]),
      .rdata(bus.data_o[c*DATA_W +: DATA_W]),
      .ack(bus.ack_o[c]),
      .level(bus.level_o[c*LW +: LW]),
      .primed(bus.primed_o[c]),
      .underflow(bus.underflow_o[c]),
      .overflow(bus.overflow_o[c])
    );
  end
endmodule

// File: tb/tb_resample_output_stage.sv
// tb_resample_output_stage: directed self-checking bench for resample_output_stage
module tb_resample_output_stage;
  import resample_pkg::*;
  localparam int NC = 8, NR = 5, DW = 24, DL = 4, LW = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  resample_output_stage_if #(.NUM_CH(NC), .NUM_RATE(NR), .DATA_W(DW), .DEPTH_LOG2(DL)) bus ();
  resample_output_stage #(
    .NUM_CH(NC), .NUM_CH_LOG2(3), .NUM_RATE(NR), .DATA_W(DW),
    .DEPTH(16), .DEPTH_LOG2(DL), .PRIME_LEVEL(4)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [DW-1:0] dat(int ch); return bus.data_o[ch*DW +: DW]; endfunction
  function automatic logic [LW-1:0] lvl(int ch); return bus.level_o[ch*LW +: LW]; endfunction
  function automatic logic [NR-1:0] onehot(int idx); logic [NR-1:0] r; r = '0; r[idx] = 1'b1; return r; endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic wr(int ch, logic [DW-1:0] d);
    bus.we_i[ch] = 1'b1; bus.data_i[ch*DW +: DW] = d; tick(); bus.we_i[ch] = 1'b0;
  endtask
  task automatic pop(int ch); bus.pop_i[ch] = 1'b1; tick(); bus.pop_i[ch] = 1'b0; endtask
  task automatic set_rate(int ch, int idx); bus.rate_i[ch*NR +: NR] = onehot(idx); endtask

  task automatic test_reset();
    #12;
    total++; if (bus.data_o !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.data_o); end
    total++; if (bus.ack_o !== '0 || bus.primed_o !== '0) begin bad++; $display("FAIL reset_ack_primed got=%h/%h exp=0/0", bus.ack_o, bus.primed_o); end
    total++; if (bus.level_o !== '0 || bus.underflow_o !== '0 || bus.overflow_o !== '0) begin bad++; $display("FAIL reset_level_flags got=%h/%h/%h exp=0", bus.level_o, bus.underflow_o, bus.overflow_o); end
    @(negedge clk) rst = 1'b1;
    repeat (3) tick();
    total++; if (bus.primed_o !== '0 || bus.level_o !== '0) begin bad++; $display("FAIL post_reset_prime got=%h/%h exp=0/0", bus.primed_o, bus.level_o); end
  endtask

  task automatic test_prime_run();
    for (int i = 1; i <= 3; i++) wr(0, DW'(i));
    total++; if (bus.primed_o[0] !== 1'b0 || lvl(0) !== LW'(3)) begin bad++; $display("FAIL t1_pre got primed=%b lvl=%0d exp 0/3", bus.primed_o[0], lvl(0)); end
    pop(0);
    total++; if (bus.ack_o[0] !== 1'b1 || dat(0) !== '0) begin bad++; $display("FAIL t1_prime_pop got ack=%b data=%h exp 1/0", bus.ack_o[0], dat(0)); end
    total++; if (bus.primed_o[0] !== 1'b0 || lvl(0) !== LW'(3)) begin bad++; $display("FAIL t1_prime_keep got primed=%b lvl=%0d exp 0/3", bus.primed_o[0], lvl(0)); end
    wr(0, DW'(4));
    total++; if (bus.primed_o[0] !== 1'b1 || lvl(0) !== LW'(4)) begin bad++; $display("FAIL t1_primed got primed=%b lvl=%0d exp 1/4", bus.primed_o[0], lvl(0)); end
    for (int k = 1; k <= 4; k++) begin
      pop(0);
      total++; if (bus.ack_o[0] !== 1'b1 || dat(0) !== DW'(k)) begin bad++; $display("FAIL t1_run_pop%0d got ack=%b data=%h exp 1/%h", k, bus.ack_o[0], dat(0), k); end
      total++; if (lvl(0) !== LW'(4 - k)) begin bad++; $display("FAIL t1_level%0d got=%0d exp=%0d", k, lvl(0), 4 - k); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) wr(1, DW'(32'h100 + i));
    total++; if (lvl(1) !== LW'(16) || bus.primed_o[1] !== 1'b1) begin bad++; $display("FAIL t2_full got lvl=%0d primed=%b exp 16/1", lvl(1), bus.primed_o[1]); end
    wr(1, 24'hABCDEF);
    total++; if (bus.overflow_o[1] !== 1'b1 || lvl(1) !== LW'(16)) begin bad++; $display("FAIL t2_overflow got of=%b lvl=%0d exp 1/16", bus.overflow_o[1], lvl(1)); end
    bus.flag_clr_i[1] = 1'b1; tick(); bus.flag_clr_i[1] = 1'b0;
    total++; if (bus.overflow_o[1] !== 1'b0) begin bad++; $display("FAIL t2_of_clear got=%b exp=0", bus.overflow_o[1]); end
    bus.we_i[1] = 1'b1; bus.data_i[DW +: DW] = 24'h555555; bus.pop_i[1] = 1'b1; tick();
    bus.we_i[1] = 1'b0; bus.pop_i[1] = 1'b0;
    total++; if (dat(1) !== 24'h000100 || lvl(1) !== LW'(16) || bus.overflow_o[1] !== 1'b0) begin bad++; $display("FAIL t2_wr_pop_full got data=%h lvl=%0d of=%b exp 000100/16/0", dat(1), lvl(1), bus.overflow_o[1]); end
    for (int i = 1; i < 16; i++) begin
      pop(1);
      total++; if (dat(1) !== DW'(32'h100 + i)) begin bad++; $display("FAIL t2_drain%0d got=%h exp=%h", i, dat(1), 32'h100 + i); end
    end
    pop(1);
    total++; if (dat(1) !== 24'h555555 || lvl(1) !== '0) begin bad++; $display("FAIL t2_last got data=%h lvl=%0d exp 555555/0", dat(1), lvl(1)); end
  endtask

  task automatic test_underflow();
    for (int i = 1; i <= 4; i++) wr(2, DW'(32'h220000 + i));
    for (int i = 1; i <= 4; i++) pop(2);
    total++; if (dat(2) !== 24'h220004 || lvl(2) !== '0 || bus.primed_o[2] !== 1'b1) begin bad++; $display("FAIL t3_setup got data=%h lvl=%0d primed=%b exp 220004/0/1", dat(2), lvl(2), bus.primed_o[2]); end
    pop(2);
    total++; if (bus.ack_o[2] !== 1'b1 || dat(2) !== '0) begin bad++; $display("FAIL t3_uf_pop got ack=%b data=%h exp 1/0", bus.ack_o[2], dat(2)); end
    total++; if (bus.underflow_o[2] !== 1'b1 || bus.primed_o[2] !== 1'b0) begin bad++; $display("FAIL t3_uf_flag got uf=%b primed=%b exp 1/0", bus.underflow_o[2], bus.primed_o[2]); end
    tick();
    total++; if (bus.underflow_o[2] !== 1'b1) begin bad++; $display("FAIL t3_sticky got=%b exp=1", bus.underflow_o[2]); end
    bus.flag_clr_i[2] = 1'b1; tick(); bus.flag_clr_i[2] = 1'b0;
    total++; if (bus.underflow_o[2] !== 1'b0) begin bad++; $display("FAIL t3_clear got=%b exp=0", bus.underflow_o[2]); end
  endtask

  task automatic test_rate_change();
    for (int i = 0; i < 6; i++) wr(3, DW'(32'h330000 + i));
    total++; if (lvl(3) !== LW'(6) || bus.primed_o[3] !== 1'b1) begin bad++; $display("FAIL t4_setup got lvl=%0d primed=%b exp 6/1", lvl(3), bus.primed_o[3]); end
    set_rate(3, RATE_192);
    bus.we_i[3] = 1'b1; bus.data_i[3*DW +: DW] = 24'hDEAD01;
    tick(); tick();
    total++; if (lvl(3) !== '0 || bus.primed_o[3] !== 1'b0) begin bad++; $display("FAIL t4_flush got lvl=%0d primed=%b exp 0/0", lvl(3), bus.primed_o[3]); end
    bus.we_i[3] = 1'b0; tick();
    total++; if (lvl(3) !== '0) begin bad++; $display("FAIL t4_ignored got=%0d exp=0", lvl(3)); end
    for (int i = 0; i < 3; i++) wr(3, DW'(32'h330100 + i));
    total++; if (bus.primed_o[3] !== 1'b0 || lvl(3) !== LW'(3)) begin bad++; $display("FAIL t4_reprime3 got primed=%b lvl=%0d exp 0/3", bus.primed_o[3], lvl(3)); end
    wr(3, 24'h330103);
    total++; if (bus.primed_o[3] !== 1'b1) begin bad++; $display("FAIL t4_reprime4 got=%b exp=1", bus.primed_o[3]); end
    pop(3);
    total++; if (dat(3) !== 24'h330100) begin bad++; $display("FAIL t4_fresh got=%h exp=330100", dat(3)); end
  endtask

  task automatic test_all_channels();
    int perm [NC] = '{5, 2, 7, 0, 3, 6, 1, 4};
    int ch;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < NC; c++) bus.data_i[c*DW +: DW] = DW'(32'hC00000 + c * 256 + k);
      bus.we_i = '1; tick();
    end
    bus.we_i = '0;
    total++; if (bus.primed_o !== '1) begin bad++; $display("FAIL t5_primed got=%h exp=ff", bus.primed_o); end
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < NC; j++) begin
        ch = perm[(j + k) % NC];
        pop(ch);
        total++; if (bus.ack_o !== NC'(1 << ch)) begin bad++; $display("FAIL t5_ack ch%0d got=%b exp=%b", ch, bus.ack_o, NC'(1 << ch)); end
        total++; if (dat(ch) !== DW'(32'hC00000 + ch * 256 + k)) begin bad++; $display("FAIL t5_data ch%0d got=%h exp=%h", ch, dat(ch), 32'hC00000 + ch * 256 + k); end
      end
    tick();
    total++; if (bus.ack_o !== '0 || bus.level_o !== '0) begin bad++; $display("FAIL t5_idle got ack=%b lvl=%h exp 0/0", bus.ack_o, bus.level_o); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) wr(0, DW'(32'h660000 + i));
    bus.pop_i[0] = 1'b1; tick();
    total++; if (bus.ack_o[0] !== 1'b1 || dat(0) !== 24'h660000 || lvl(0) !== LW'(3)) begin bad++; $display("FAIL t6_pre got ack=%b data=%h lvl=%0d exp 1/660000/3", bus.ack_o[0], dat(0), lvl(0)); end
    #3 rst = 1'b0;
    #1;
    total++; if (bus.data_o !== '0 || bus.ack_o !== '0 || bus.level_o !== '0) begin bad++; $display("FAIL t6_async got data=%h ack=%b lvl=%h exp 0", bus.data_o, bus.ack_o, bus.level_o); end
    total++; if (bus.primed_o !== '0 || bus.underflow_o !== '0 || bus.overflow_o !== '0) begin bad++; $display("FAIL t6_async_flags got %h/%h/%h exp 0", bus.primed_o, bus.underflow_o, bus.overflow_o); end
    tick();
    total++; if (bus.ack_o !== '0) begin bad++; $display("FAIL t6_no_ack got=%b exp=0", bus.ack_o); end
    #2 rst = 1'b1;
    tick(); bus.pop_i[0] = 1'b0;
    total++; if (bus.ack_o[0] !== 1'b1 || dat(0) !== '0 || lvl(0) !== '0) begin bad++; $display("FAIL t6_after got ack=%b data=%h lvl=%0d exp 1/0/0", bus.ack_o[0], dat(0), lvl(0)); end
  endtask

  initial begin
    bus.we_i = '0; bus.pop_i = '0; bus.flag_clr_i = '0; bus.data_i = '0;
    for (int c = 0; c < NC; c++) set_rate(c, c % NR);
    set_rate(0, RATE_48);
    set_rate(3, RATE_96);
    test_reset();
    test_prime_run();
    test_overflow();
    test_underflow();
    test_rate_change();
    test_all_channels();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/resample_output_stage.md
Name: resample_output_stage

Overview:
- Parametrised per-channel output buffer stage for the resampler pipeline; replaces the fixed 24-bit, fixed-depth 192kHz ring-buffer stage.
- Each channel has a ring buffer with a configurable depth and a FLUSH/PRIME/RUN state machine. It sits between the last resampler/muxer and the downstream consumer.
- Adds fill-level reporting, sticky overflow/underflow flags, automatic flush on rate change, and zero-output priming until the buffer holds enough samples.

Parameters:
- NUM_CH, 8, channel count
- NUM_CH_LOG2, 3, log2(NUM_CH)
- NUM_RATE, 5, width of the per-channel one-hot rate field
- DATA_W, 24, sample width
- DEPTH, 16, ring buffer entries per channel (power of two)
- DEPTH_LOG2, 4, log2(DEPTH)
- PRIME_LEVEL, 4, fill level needed to leave PRIME (1..DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- rate_i  in  NUM_RATE*NUM_CH  per-channel one-hot rate selection
- we_i  in  NUM_CH  per-channel write strobe (upstream ack)
- data_i  in  DATA_W*NUM_CH  per-channel write data
- pop_i  in  NUM_CH  per-channel read request from the consumer
- data_o  out  DATA_W*NUM_CH  per-channel registered read data
- ack_o  out  NUM_CH  per-channel read acknowledge
- level_o  out  (DEPTH_LOG2+1)*NUM_CH  per-channel fill level, 0..DEPTH
- primed_o  out  NUM_CH  1 when the channel is in RUN
- underflow_o  out  NUM_CH  sticky underflow flag
- overflow_o  out  NUM_CH  sticky overflow flag
- flag_clr_i  in  NUM_CH  clears the sticky flags, per channel

Behaviour:
- Reset (rst=0, asynchronous):
  - every channel goes to FLUSH.
  - rd/wr pointers = 0; level = 0.
  - data_o = 0, ack_o = 0, primed_o = 0, underflow_o = 0, overflow_o = 0.
  - registered rate copy = 0.
- Per-channel states: FLUSH, PRIME, RUN. Channels are fully independent.
- Rate-change detect: the channel registers its rate_i field every cycle. If the field differs from the registered copy, or is all-zero, the next state is FLUSH (overrides all other transitions).
- FLUSH:
  - pointers and level are cleared; we_i is ignored.
  - pop_i is still acked, with data_o = 0.
  - Leaves to PRIME in the cycle after the rate field is stable and non-zero. Minimum one cycle in FLUSH.
- PRIME:
  - writes are accepted; pops are acked with data_o = 0 and do not consume entries.
  - Goes to RUN on the cycle level reaches >= PRIME_LEVEL, counting the write in that cycle.
- RUN:
  - pop reads the oldest entry; rd_ptr advances mod DEPTH.
  - Pop while level = 0 (with no write in the same cycle): data_o = 0, underflow_o sets, state goes to PRIME.
  - A same-cycle write and pop at level 0 is an underflow; the written sample is stored.
- Handshake:
  - ack_o = pop_i delayed exactly one cycle.
  - data_o updates in the same cycle ack_o rises and holds its value until the next ack.
  - Pops are acked in every state.
- Write when level = DEPTH with no same-cycle consuming pop: sample dropped, overflow_o sets, pointers unchanged.
- A write and a consuming pop in the same cycle at full: both proceed; level stays DEPTH; no overflow.
- Level update per cycle:
  - +1 on an accepted write, -1 on a consuming pop; a simultaneous write and pop leaves level unchanged.
  - level never leaves 0..DEPTH.
  - level_o is registered.
- Pointers are DEPTH_LOG2 bits and wrap naturally.
- Sticky flags:
  - flag_clr_i clears a flag the next cycle.
  - If a set event and a clear hit the same cycle, set wins.
- Storage: distributed RAM, asynchronous read, with data_o registered after the read.
- Reset asserted mid-transfer: all state is lost immediately; no ack is produced for a pop issued in the reset cycle.

Decomposition:
- Package resample_pkg:
  - RATE_32 = 0, RATE_441 = 1, RATE_48 = 2, RATE_96 = 3, RATE_192 = 4
  - state encoding ST_FLUSH / ST_PRIME / ST_RUN (2 bits)
- Sub-module resample_chbuf: one channel's ring buffer, FSM, level counter and flags.
- The top level is a generate loop that slices the buses and instantiates resample_chbuf NUM_CH times.

Test Plan:
- Reset, then ch0 rate=RATE_48: 3 writes 0x000001..0x000003, then pop. Required: ack next cycle with data_o = 0, primed_o = 0. 4th write -> primed_o = 1; the next 4 pops return 1, 2, 3, 4 in order, and level_o goes 4 -> 0.
- Fill ch1 to 16 entries, write 0xABCDEF. Required: overflow_o[1] = 1, level_o stays 16, and the 16 pops return the original data. Write and pop together at full: no overflow, level stays 16.
- ch2 in RUN with level = 0, pop. Required: ack with data_o = 0, underflow_o[2] = 1, state PRIME (primed_o = 0). flag_clr_i[2] pulse clears the flag the next cycle.
- ch3 RUN with level 6, change rate RATE_96 -> RATE_192. Required: level_o = 0 within 2 cycles, primed_o = 0, and writes during FLUSH are ignored. Re-priming needs 4 fresh writes.
- Write to all 8 channels with different data and pop in a staggered order. Required: no cross-channel interference, and each ack_o[i] comes exactly 1 cycle after its pop_i[i].
- Assert rst = 0 asynchronously, mid-clock, with levels non-zero. Required: all outputs are 0 before the next clock edge; after release, pops are acked with data_o = 0.
